// File: rtl/ifetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit and memory.
// The fetch unit drives the master side; memory (or a bench model) the slave side.
interface ifetch_unit_if #(
    parameter int ADDR_W = 32
);
    logic              imemReq;
    logic [ADDR_W-1:0] imemAddr;
    logic              imemAck;
    logic [31:0]       imemData;

    modport master (
        output imemReq,
        output imemAddr,
        input  imemAck,
        input  imemData
    );

    modport slave (
        input  imemReq,
        input  imemAddr,
        output imemAck,
        output imemData
    );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch / IR block: IDLE -> REQ -> DONE fetch of one word per fecAbl, plus PC upkeep.
// Optional feature macro IFETCH_TIMEOUT_EN: abandon a request after TIMEOUT cycles without ack.
module ifetch_unit #(
    parameter int              ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int              TIMEOUT  = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fecAbl,
    input  logic              pcLoad,
    input  logic [ADDR_W-1:0] pcNew,
    ifetch_unit_if.master     imem,
    output logic [31:0]       irOut,
    output logic [5:0]        irOutOpe,
    output logic [5:0]        irOutFunct,
    output logic [ADDR_W-1:0] pcOut,
    output logic              irValid,
    output logic              busy,
    output logic              fetchErr
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       ir_q, ir_d;
    logic              ir_valid_q, ir_valid_d;
    logic              req_q, req_d;
    logic              busy_q, busy_d;

`ifdef IFETCH_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
`endif

    // Next-state and next-value logic for the fetch sequencer and PC.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        addr_d     = addr_q;
        ir_d       = ir_q;
        ir_valid_d = ir_valid_q;
        req_d      = req_q;
`ifdef IFETCH_TIMEOUT_EN
        cnt_d      = cnt_q;
        err_d      = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (fecAbl) begin
                    state_d    = S_REQ;
                    addr_d     = pc_q;
                    req_d      = 1'b1;
                    ir_valid_d = 1'b0;
`ifdef IFETCH_TIMEOUT_EN
                    cnt_d      = '0;
                    err_d      = 1'b0;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                if (imem.imemAck) begin
                    state_d    = S_DONE;
                    ir_d       = imem.imemData;
                    pc_d       = addr_q + ADDR_W'(4);
                    ir_valid_d = 1'b1;
                    req_d      = 1'b0;
`ifdef IFETCH_TIMEOUT_EN
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    // The count would reach TIMEOUT on this edge: give up, leave PC/IR alone.
                    state_d = S_IDLE;
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`else
                end else begin
                    state_d = S_REQ;
                end
`endif
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
            end
        endcase

        // A branch/jump load beats the sequential increment on the same edge.
        if (pcLoad) begin
            pc_d = {pcNew[ADDR_W-1:2], 2'b00};
        end else begin
            pc_d = pc_d;
        end

        busy_d = (state_d != S_IDLE);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            addr_q     <= '0;
            ir_q       <= 32'h0000_0000;
            ir_valid_q <= 1'b0;
            req_q      <= 1'b0;
            busy_q     <= 1'b0;
`ifdef IFETCH_TIMEOUT_EN
            cnt_q      <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
            req_q      <= req_d;
            busy_q     <= busy_d;
`ifdef IFETCH_TIMEOUT_EN
            cnt_q      <= cnt_d;
            err_q      <= err_d;
`endif
        end
    end

    // busy_q tracks (state_q != IDLE) exactly, registered alongside the state.
    assign busy          = busy_q;
    assign imem.imemReq  = req_q;
    assign imem.imemAddr = addr_q;
    assign irOut         = ir_q;
    assign irOutOpe      = ir_q[31:26];
    assign irOutFunct    = ir_q[5:0];
    assign pcOut         = pc_q;
    assign irValid       = ir_valid_q;

`ifdef IFETCH_TIMEOUT_EN
    assign fetchErr = err_q;
`else
    assign fetchErr = 1'b0;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed self-checking bench for ifetch_unit; also covers the timeout path when
// IFETCH_TIMEOUT_EN is defined.
module tb_ifetch_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fecAbl = 1'b0;
    logic        pcLoad = 1'b0;
    logic [31:0] pcNew = 32'h0;
    logic [31:0] irOut;
    logic [5:0]  irOutOpe;
    logic [5:0]  irOutFunct;
    logic [31:0] pcOut;
    logic        irValid;
    logic        busy;
    logic        fetchErr;
    int          total = 0;
    int          bad = 0;

    ifetch_unit_if #(.ADDR_W(32)) imem ();

    ifetch_unit #(.ADDR_W(32), .RESET_PC(32'h0), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .fecAbl(fecAbl), .pcLoad(pcLoad), .pcNew(pcNew),
        .imem(imem), .irOut(irOut), .irOutOpe(irOutOpe), .irOutFunct(irOutFunct),
        .pcOut(pcOut), .irValid(irValid), .busy(busy), .fetchErr(fetchErr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; imem.imemAck = 1'b0; imem.imemData = 32'h0;
        tick(); tick();
        total++;
        if (pcOut !== 32'h0 || irOut !== 32'h0 || irValid !== 1'b0 || imem.imemReq !== 1'b0 ||
            imem.imemAddr !== 32'h0 || busy !== 1'b0 || fetchErr !== 1'b0) begin
            bad++;
            $display("FAIL reset_state got pc=%h ir=%h v=%b req=%b addr=%h busy=%b err=%b exp all 0",
                     pcOut, irOut, irValid, imem.imemReq, imem.imemAddr, busy, fetchErr);
        end
        rst = 1'b1;
    endtask

    task automatic test_fetch();
        int busy_cycles = 0;
        fecAbl = 1'b1; tick(); fecAbl = 1'b0;
        if (busy) busy_cycles++;
        total++;
        if (imem.imemReq !== 1'b1 || imem.imemAddr !== 32'h0 || irValid !== 1'b0) begin
            bad++; $display("FAIL fetch_req got req=%b addr=%h v=%b exp 1 0 0", imem.imemReq, imem.imemAddr, irValid);
        end
        tick();
        if (busy) busy_cycles++;
        imem.imemAck = 1'b1; imem.imemData = 32'h8C22_0004;
        tick(); imem.imemAck = 1'b0;
        if (busy) busy_cycles++;
        total++;
        if (irOut !== 32'h8C22_0004 || irOutOpe !== 6'h23 || irOutFunct !== 6'h04) begin
            bad++; $display("FAIL fetch_ir got ir=%h ope=%h fn=%h exp 8c220004 23 04", irOut, irOutOpe, irOutFunct);
        end
        total++;
        if (irValid !== 1'b1 || pcOut !== 32'h4 || imem.imemReq !== 1'b0) begin
            bad++; $display("FAIL fetch_pc got v=%b pc=%h req=%b exp 1 4 0", irValid, pcOut, imem.imemReq);
        end
        tick();
        if (busy) busy_cycles++;
        total++;
        if (busy_cycles != 3 || irValid !== 1'b1) begin
            bad++; $display("FAIL fetch_busy got busy_cycles=%0d v=%b exp 3 1", busy_cycles, irValid);
        end
    endtask

    task automatic test_wait_states();
        fecAbl = 1'b1; tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (imem.imemReq !== 1'b1 || imem.imemAddr !== 32'h4 || irOut !== 32'h8C22_0004 || irValid !== 1'b0) begin
                bad++; $display("FAIL wait_hold[%0d] got req=%b addr=%h ir=%h v=%b exp 1 4 8c220004 0",
                                i, imem.imemReq, imem.imemAddr, irOut, irValid);
            end
        end
        imem.imemAck = 1'b1; imem.imemData = 32'h0022_1820;
        tick(); imem.imemAck = 1'b0;
        total++;
        if (irOut !== 32'h0022_1820 || pcOut !== 32'h8 || irOutFunct !== 6'h20) begin
            bad++; $display("FAIL wait_ir got ir=%h pc=%h fn=%h exp 00221820 8 20", irOut, pcOut, irOutFunct);
        end
        tick(); fecAbl = 1'b0;
        total++;
        if (busy !== 1'b0 || imem.imemReq !== 1'b0 || irValid !== 1'b1) begin
            bad++; $display("FAIL wait_ignore got busy=%b req=%b v=%b exp 0 0 1", busy, imem.imemReq, irValid);
        end
    endtask

    task automatic test_branch_collision();
        fecAbl = 1'b1; tick(); fecAbl = 1'b0;
        imem.imemAck = 1'b1; imem.imemData = 32'h1234_5678; pcLoad = 1'b1; pcNew = 32'h103;
        tick(); imem.imemAck = 1'b0; pcLoad = 1'b0;
        total++;
        if (pcOut !== 32'h100 || irOut !== 32'h1234_5678 || irValid !== 1'b1) begin
            bad++; $display("FAIL branch_collide got pc=%h ir=%h v=%b exp 100 12345678 1", pcOut, irOut, irValid);
        end
        tick();
        fecAbl = 1'b1; tick(); fecAbl = 1'b0;
        pcLoad = 1'b1; pcNew = 32'h200; tick(); pcLoad = 1'b0;
        total++;
        if (imem.imemAddr !== 32'h100 || imem.imemReq !== 1'b1 || pcOut !== 32'h200) begin
            bad++; $display("FAIL branch_midreq got addr=%h req=%b pc=%h exp 100 1 200", imem.imemAddr, imem.imemReq, pcOut);
        end
        imem.imemAck = 1'b1; imem.imemData = 32'hAAAA_5555;
        tick(); imem.imemAck = 1'b0;
        total++;
        if (pcOut !== 32'h104 || irOut !== 32'hAAAA_5555) begin
            bad++; $display("FAIL branch_after got pc=%h ir=%h exp 104 aaaa5555", pcOut, irOut);
        end
        tick();
    endtask

    task automatic test_reset_mid_fetch();
        fecAbl = 1'b1; tick(); fecAbl = 1'b0;
        tick();
        rst = 1'b0; tick(); rst = 1'b1;
        total++;
        if (pcOut !== 32'h0 || irOut !== 32'h0 || irValid !== 1'b0 || imem.imemReq !== 1'b0 ||
            imem.imemAddr !== 32'h0 || busy !== 1'b0 || fetchErr !== 1'b0) begin
            bad++; $display("FAIL midreset_state got pc=%h ir=%h v=%b req=%b addr=%h busy=%b err=%b exp all 0",
                            pcOut, irOut, irValid, imem.imemReq, imem.imemAddr, busy, fetchErr);
        end
        imem.imemAck = 1'b1; imem.imemData = 32'hDEAD_BEEF;
        tick(); imem.imemAck = 1'b0;
        total++;
        if (irValid !== 1'b0 || irOut !== 32'h0 || pcOut !== 32'h0 || busy !== 1'b0) begin
            bad++; $display("FAIL midreset_lateack got v=%b ir=%h pc=%h busy=%b exp 0 0 0 0", irValid, irOut, pcOut, busy);
        end
    endtask

    task automatic test_wrap();
        pcLoad = 1'b1; pcNew = 32'hFFFF_FFFC; tick(); pcLoad = 1'b0;
        fecAbl = 1'b1; tick(); fecAbl = 1'b0;
        total++;
        if (imem.imemAddr !== 32'hFFFF_FFFC || pcOut !== 32'hFFFF_FFFC) begin
            bad++; $display("FAIL wrap_addr got addr=%h pc=%h exp fffffffc fffffffc", imem.imemAddr, pcOut);
        end
        imem.imemAck = 1'b1; imem.imemData = 32'h03E0_0008;
        tick(); imem.imemAck = 1'b0;
        total++;
        if (pcOut !== 32'h0 || irOutOpe !== 6'h00 || irOutFunct !== 6'h08) begin
            bad++; $display("FAIL wrap_pc got pc=%h ope=%h fn=%h exp 0 00 08", pcOut, irOutOpe, irOutFunct);
        end
        tick();
    endtask

`ifdef IFETCH_TIMEOUT_EN
    task automatic test_timeout();
        fecAbl = 1'b1; tick(); fecAbl = 1'b0;
        for (int i = 1; i < 15; i++) tick();
        total++;
        if (imem.imemReq !== 1'b1 || fetchErr !== 1'b0) begin
            bad++; $display("FAIL timeout_early got req=%b err=%b exp 1 0", imem.imemReq, fetchErr);
        end
        tick();
        total++;
        if (imem.imemReq !== 1'b0 || fetchErr !== 1'b1 || busy !== 1'b0 || pcOut !== 32'h0 ||
            irValid !== 1'b0 || irOut !== 32'h03E0_0008) begin
            bad++; $display("FAIL timeout_fire got req=%b err=%b busy=%b pc=%h v=%b ir=%h exp 0 1 0 0 0 03e00008",
                            imem.imemReq, fetchErr, busy, pcOut, irValid, irOut);
        end
        tick();
        total++;
        if (fetchErr !== 1'b1) begin
            bad++; $display("FAIL timeout_sticky got err=%b exp 1", fetchErr);
        end
        fecAbl = 1'b1; tick(); fecAbl = 1'b0;
        total++;
        if (fetchErr !== 1'b0 || imem.imemReq !== 1'b1) begin
            bad++; $display("FAIL timeout_clear got err=%b req=%b exp 0 1", fetchErr, imem.imemReq);
        end
        for (int i = 1; i < 15; i++) tick();
        imem.imemAck = 1'b1; imem.imemData = 32'h2108_0001;
        tick(); imem.imemAck = 1'b0;
        total++;
        if (irValid !== 1'b1 || fetchErr !== 1'b0 || pcOut !== 32'h4 || irOut !== 32'h2108_0001) begin
            bad++; $display("FAIL timeout_edge_ack got v=%b err=%b pc=%h ir=%h exp 1 0 4 21080001",
                            irValid, fetchErr, pcOut, irOut);
        end
        tick();
    endtask
`else
    task automatic test_no_timeout();
        fecAbl = 1'b1; tick(); fecAbl = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        total++;
        if (imem.imemReq !== 1'b1 || busy !== 1'b1 || fetchErr !== 1'b0) begin
            bad++; $display("FAIL no_timeout got req=%b busy=%b err=%b exp 1 1 0", imem.imemReq, busy, fetchErr);
        end
        imem.imemAck = 1'b1; imem.imemData = 32'h2108_0001;
        tick(); imem.imemAck = 1'b0;
        total++;
        if (irValid !== 1'b1 || pcOut !== 32'h4 || irOut !== 32'h2108_0001) begin
            bad++; $display("FAIL no_timeout_ack got v=%b pc=%h ir=%h exp 1 4 21080001", irValid, pcOut, irOut);
        end
        tick();
    endtask
`endif

    initial begin
        imem.imemAck = 1'b0;
        imem.imemData = 32'h0;
        test_reset();
        test_fetch();
        test_wait_states();
        test_branch_collision();
        test_reset_mid_fetch();
        test_wrap();
`ifdef IFETCH_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction fetch and instruction-register block for the multi-cycle CPU.
- Responds to the control unit's fetch-enable, fetches one word from instruction memory over a req/ack handshake, and holds it in the IR.
- Returns the opcode and funct fields to the control unit and maintains the PC, including branch/jump loads from the datapath.

Parameters:
- ADDR_W, 32, PC/instruction address width.
- RESET_PC, 0, PC value after reset (word aligned).
- TIMEOUT, 15, maximum cycles waiting for imemAck (used only with the optional feature).

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-low (rst==0 at a rising edge resets)
- fecAbl  in  1  fetch enable from control unit; sampled only in IDLE
- pcLoad  in  1  load PC from pcNew
- pcNew  in  ADDR_W  branch/jump target
- imemReq  out  1  instruction memory request
- imemAddr  out  ADDR_W  request address, stable while imemReq=1
- imemAck  in  1  memory acknowledge, data valid this cycle
- imemData  in  32  instruction word
- irOut  out  32  full instruction register
- irOutOpe  out  6  irOut[31:26]
- irOutFunct  out  6  irOut[5:0]
- pcOut  out  ADDR_W  current PC
- irValid  out  1  IR holds a freshly fetched instruction
- busy  out  1  fetch in progress (state != IDLE)
- fetchErr  out  1  fetch timed out (optional feature; 0 otherwise)

Behaviour:
- Reset values (rst==0 at edge, in any state, including mid-fetch):
  - state=IDLE, pc=RESET_PC, irOut=0, irValid=0, imemReq=0, imemAddr=0, busy=0, fetchErr=0.
  - Pending fetches are abandoned; a late imemAck is ignored.
- States: IDLE, REQ, DONE.
- IDLE:
  - fecAbl=1 at edge → REQ.
  - On that edge: latch addrReg<=pc, imemReq<=1, irValid<=0, fetchErr<=0.
  - fecAbl=0 → stay in IDLE.
- REQ:
  - imemReq=1 and imemAddr=addrReg, held constant until ack.
  - imemAck=1 at edge: irOut<=imemData, pc<=addrReg+4, irValid<=1, imemReq<=0 → DONE.
  - imemAck=0 → stay in REQ.
- DONE:
  - Single cycle, busy=1 → IDLE.
  - Gives the control unit one decode cycle with stable irOutOpe.
- fecAbl outside IDLE is ignored; no queuing.
- Latency:
  - fecAbl at edge N → imemReq high after N.
  - Ack sampled at edge N+1 at earliest → irValid/irOut updated after N+1.
  - busy falls after N+2.
- irValid is a level: stays 1 until the next accepted fecAbl or reset.
- PC and pcLoad:
  - pcLoad=1 at any edge: pc<=pcNew with bits [1:0] forced to 0.
  - If pcLoad coincides with the ack edge, pcLoad wins over addrReg+4.
  - pcLoad never alters addrReg or an outstanding request.
- Arithmetic: pc+4 wraps modulo 2^ADDR_W; no overflow flag.
- busy = (state != IDLE), combinational from the state register.
- irOutOpe and irOutFunct are pure slices of irOut.

Optional Feature:
- Macro: IFETCH_TIMEOUT_EN.
- Defined:
  - A counter clears on REQ entry and increments each cycle in REQ without ack.
  - If the count reaches TIMEOUT with imemAck=0 at that edge: imemReq<=0, fetchErr<=1, state → IDLE.
  - pc, irOut and irValid(0) are unchanged.
  - fetchErr is sticky until the next accepted fecAbl or reset.
  - Ack on the same edge the count hits TIMEOUT counts as success.
- Undefined:
  - REQ waits indefinitely.
  - fetchErr is tied to 0.
  - No counter logic is generated.

Test Plan:
- Reset then fetch:
  - Stimulus: rst=0 for 2 cycles, RESET_PC=0; fecAbl pulse; memory acks 1 cycle after req with 0x8C220004.
  - Required: imemAddr=0; irOut=0x8C220004; irOutOpe=0x23; irOutFunct=0x04; irValid=1; pcOut=4; busy high for exactly 3 cycles.
- Wait states:
  - Stimulus: ack delayed 5 cycles.
  - Required: imemReq and imemAddr stable throughout; fecAbl pulses during busy ignored; exactly one IR update.
- Branch collision:
  - Stimulus: pcLoad=1 with pcNew=0x103 on the ack edge.
  - Required: pcOut=0x100 (not addrReg+4); irOut holds the fetched word.
- Reset mid-fetch:
  - Stimulus: rst=0 while in REQ; then ack arrives after reset.
  - Required: all outputs at reset values; late ack ignored; irValid stays 0.
- Wrap-around:
  - Stimulus: pcLoad pcNew=0xFFFFFFFC; then fetch with ack.
  - Required: pcOut=0x00000000.
- With IFETCH_TIMEOUT_EN, TIMEOUT=15:
  - Stimulus: no ack.
  - Required: imemReq drops after 15 REQ cycles; fetchErr=1; pc unchanged; next fecAbl clears fetchErr.
